// File: rtl/adder_4_seq_ctrl.sv
// rtl/adder_4_seq_ctrl.sv - multi-cycle W-bit adder, one 4-bit nibble per clock
// Optional subtract mode (port sub) enabled by defining ADDER_SEQ_SUB_EN.
module adder_4_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    input  logic [4*NIB-1:0] op_a,
    input  logic [4*NIB-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [IW+1:0] base;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [4:0]    nib_sum;
    logic          msb_cin;

    assign base    = {idx_q, 2'b00};
    assign a_nib   = a_q[base +: 4];
    assign b_nib   = b_q[base +: 4];
    assign nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // Carry into bit 3 of the nibble; only meaningful for the top nibble.
    assign msb_cin = a_nib[3] ^ b_nib[3] ^ nib_sum[3];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
`ifdef ADDER_SEQ_SUB_EN
                    // Subtraction is a + ~b + 1; the caller's cin is ignored.
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = op_b;
                    carry_d = cin;
`endif
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[base +: 4] = nib_sum[3:0];
                carry_d          = nib_sum[4];
                idx_d            = idx_q + IW'(1);
                if (idx_q == IW'(NIB - 1)) begin
                    idx_d   = '0;
                    cout_d  = nib_sum[4];
                    ovf_d   = msb_cin ^ nib_sum[4];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_4_seq_ctrl.sv
// tb/tb_adder_4_seq_ctrl.sv - self-checking bench for adder_4_seq_ctrl
// Subtract cases are exercised when ADDER_SEQ_SUB_EN is defined.
module tb_adder_4_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    adder_4_seq_ctrl #(.NIB(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef ADDER_SEQ_SUB_EN
        .sub   (sub),
`endif
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic s,
                                  output logic [W-1:0] es, output logic ec, output logic eo);
        longint ua, ub, u, sa, sb, r;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb = b[W-1] ? ub - (longint'(1) << W) : ub;
        if (s) begin
            u  = ua - ub;
            ec = (ua >= ub);
            r  = sa - sb;
        end else begin
            u  = ua + ub + longint'(c);
            ec = u[W];
            r  = sa + sb + longint'(c);
        end
        es = u[W-1:0];
        eo = (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        logic [W-1:0] es;
        logic         ec, eo;
        model(a, b, c, s, es, ec, eo);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after T0; the result must not depend on them.
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < NIB; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            @(negedge clk);
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("sum", sum, es);
        check("cout", cout, ec);
        check("ovf", ovf, eo);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("sum_hold", sum, es);
        check("cout_hold", cout, ec);
        sub = 1'b0;
    endtask

    logic [W-1:0] a_arr [0:63];
    logic [W-1:0] b_arr [0:63];
    logic         c_arr [0:63];

    initial begin
        int last_done, n_done, exp_done;
        logic [W-1:0] es;
        logic         ec, eo;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

        // Continuous start with operands changing every cycle.
        last_done = -1;
        n_done    = 0;
        @(negedge clk);
        start = 1'b1;
        a_arr[0] = W'($urandom); b_arr[0] = W'($urandom); c_arr[0] = 1'($urandom);
        op_a = a_arr[0]; op_b = b_arr[0]; cin = c_arr[0];
        for (int e = 0; e < 42; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                model(a_arr[e-NIB], b_arr[e-NIB], c_arr[e-NIB], 1'b0, es, ec, eo);
                check("cont_sum", sum, es);
                check("cont_cout", cout, ec);
                if (last_done >= 0)
                    check("cont_spacing", e - last_done, NIB + 2);
                last_done = e;
                n_done++;
            end
            a_arr[e+1] = W'($urandom); b_arr[e+1] = W'($urandom); c_arr[e+1] = 1'($urandom);
            op_a = a_arr[e+1]; op_b = b_arr[e+1]; cin = c_arr[e+1];
        end
        exp_done = (42 - 1 - NIB) / (NIB + 2) + 1;
        check("cont_done_count", n_done, exp_done);
        start = 1'b0;
        repeat (NIB + 2) @(negedge clk);

        // Reset mid-RUN, with start held high across reset.
        run_op(16'hA5A5, 16'h1111, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; op_a = 16'h3333; op_b = 16'h4444; cin = 1'b0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_sum", sum, 0);
        check("async_rst_cout", cout, 0);
        check("async_rst_ovf", ovf, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_prio_busy", busy, 0);
        start = 1'b0;
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_done_after_abort", n_done, 0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

`ifdef ADDER_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
